// File: rtl/fir_decimator.sv
// Block-averaging decimator: sums DECIM valid samples, emits the floored mean
// through a small FIFO with a valid/ready output and a sticky overrun flag.
module fir_decimator #(
  parameter int DW         = 12,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 data_in,
  input  logic                          in_valid,
  output logic [DW-1:0]                 data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);

  localparam int SH   = $clog2(DECIM);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int ACCW = DW + SH;

  logic signed [ACCW-1:0] acc_q, acc_d, sum;
  logic [SH-1:0]          ph_q, ph_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overrun_q, overrun_d;
  logic [DW-1:0]          mem_q [FIFO_DEPTH];
  logic [DW-1:0]          result;
  logic                   grp_done, full, pop, push;

  always_comb begin
    sum      = acc_q + $signed({{SH{data_in[DW-1]}}, data_in});
    // Mean of DW-bit samples always fits DW bits, so truncation is exact.
    result   = DW'(sum >>> SH);
    grp_done = in_valid && (ph_q == SH'(DECIM - 1));
    full     = (level_q == LW'(FIFO_DEPTH));
    pop      = (level_q != '0) && out_ready;
    push     = grp_done && (!full || pop);

    acc_d     = acc_q;
    ph_d      = ph_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;

    if (in_valid) begin
      if (grp_done) begin
        acc_d = '0;
        ph_d  = '0;
      end else begin
        acc_d = sum;
        ph_d  = ph_q + SH'(1);
      end
    end

    // A completed group is dropped when full, but the phase still restarts.
    if (grp_done && !push) overrun_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      ph_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ph_q      <= ph_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result;
  end

  assign out_valid  = (level_q != '0);
  assign data_out   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Scenario tests for fir_decimator; a negedge monitor checks every popped
// output against a queue of expected results filled as stimulus is driven.
module tb_fir_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] data_in = '0;
  logic        in_valid = 1'b0;
  logic [11:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int sb[$];

  fir_decimator #(.DW(12), .DECIM(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard: a pop happens on the coming rising edge, compare its data now.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      int e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %0d required no output", $signed(data_out));
      end else begin
        e = sb.pop_front();
        if (data_out !== 12'(e)) begin
          bad++;
          $display("FAIL sb_data: got %0d required %0d", $signed(data_out), e);
        end else
          $display("pop data_out=%0d", $signed(data_out));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    in_valid = 1'b1;
    data_in  = 12'(s);
    cycle();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    cycle();
  endtask

  task automatic test_reset();
    cycle();
    total++; if (data_out !== 12'd0) begin bad++; $display("FAIL rst_data: got %0d required 0", data_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b required 0", overrun); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_groups();
    out_ready = 1'b1;
    sb.push_back(-1);
    send(-3); send(1); send(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL grp_early: got %b required 0", out_valid); end
    send(-2);
    total++; if (out_valid !== 1'b1 || data_out !== 12'hFFF) begin bad++; $display("FAIL grp1_out: got v=%b d=%0d required v=1 d=-1", out_valid, $signed(data_out)); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL grp1_level: got %0d required 1", fifo_level); end
    sb.push_back(1);
    send(-1);
    total++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL grp1_pulse: got lvl=%0d v=%b required 0 0", fifo_level, out_valid); end
    send(4); send(-5); send(6);
    total++; if (out_valid !== 1'b1 || data_out !== 12'd1) begin bad++; $display("FAIL grp2_out: got v=%b d=%0d required v=1 d=1", out_valid, $signed(data_out)); end
    idle(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL grp2_pulse: got %b required 0", out_valid); end
  endtask

  task automatic test_rounding();
    int smp[4][4] = '{'{1, 1, 1, 0}, '{-1, 0, 0, 0},
                      '{2047, 2047, 2047, 2047}, '{-2048, -2048, -2048, -2048}};
    int res[4] = '{0, -1, 2047, -2048};
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      sb.push_back(res[g]);
      for (int k = 0; k < 4; k++) send(smp[g][k]);
      total++;
      if (out_valid !== 1'b1 || data_out !== 12'(res[g])) begin
        bad++;
        $display("FAIL round_%0d: got v=%b d=%0d required v=1 d=%0d", g, out_valid, $signed(data_out), res[g]);
      end
      idle(1);
    end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    sb.push_back(4);
    for (int k = 0; k < 3; k++) begin
      send(4);
      idle(3);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_early_%0d: got %b required 0", k, out_valid); end
    end
    send(4);
    total++; if (out_valid !== 1'b1 || data_out !== 12'd4) begin bad++; $display("FAIL gap_out: got v=%b d=%0d required v=1 d=4", out_valid, $signed(data_out)); end
    idle(2);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    for (int g = 1; g <= 5; g++) begin
      if (g <= 4) sb.push_back(g);
      for (int k = 0; k < 4; k++) send(g);
      if (g == 4) begin
        total++; if (fifo_level !== 3'd4 || overrun !== 1'b0) begin bad++; $display("FAIL ovr_fill: got lvl=%0d ovr=%b required 4 0", fifo_level, overrun); end
      end
    end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovr_level: got %0d required 4", fifo_level); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (data_out !== 12'(i)) begin bad++; $display("FAIL ovr_drain_%0d: got %0d required %0d", i, $signed(data_out), i); end
      cycle();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty: got %b required 0", out_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
  endtask

  task automatic test_full_pushpop();
    apply_reset();
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) begin
      sb.push_back(g);
      for (int k = 0; k < 4; k++) send(g);
    end
    sb.push_back(5);
    send(5); send(5); send(5);
    out_ready = 1'b1;
    send(5);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL pp_level: got %0d required 4", fifo_level); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL pp_overrun: got %b required 0", overrun); end
    total++; if (data_out !== 12'd2) begin bad++; $display("FAIL pp_head: got %0d required 2", $signed(data_out)); end
    idle(4);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_drained: got %b required 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 2; g++) for (int k = 0; k < 4; k++) send(3 * (g + 1));
    send(8); send(8);
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL ar_pre_level: got %0d required 2", fifo_level); end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || data_out !== 12'd0) begin bad++; $display("FAIL ar_out: got v=%b d=%0d required 0 0", out_valid, $signed(data_out)); end
    total++; if (fifo_level !== 3'd0 || overrun !== 1'b0) begin bad++; $display("FAIL ar_state: got lvl=%0d ovr=%b required 0 0", fifo_level, overrun); end
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    cycle();
    sb.push_back(8);
    send(8); send(8); send(8);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_early: got %b required 0", out_valid); end
    send(8);
    total++; if (out_valid !== 1'b1 || data_out !== 12'd8) begin bad++; $display("FAIL ar_out8: got v=%b d=%0d required v=1 d=8", out_valid, $signed(data_out)); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_groups();
    test_rounding();
    test_gaps();
    test_overrun();
    test_full_pushpop();
    test_async_reset();
    idle(3);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
